// File: rtl/bus_autoclear_regs_pkg.sv
// Shared constants and address decode for the autoclear register bank.
// Latency: n/a (package); backpressure: n/a.
package bus_autoclear_regs_pkg;

    localparam int BUS_DW = 16;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_START    = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_STOP     = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_HISTORY  = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_HIST_CLR = 4'h8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_START,
        SEL_STATUS,
        SEL_STOP,
        SEL_HISTORY,
        SEL_HIST_CLR
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_START:    sel = SEL_START;
            ADDR_STATUS:   sel = SEL_STATUS;
            ADDR_STOP:     sel = SEL_STOP;
            ADDR_HISTORY:  sel = SEL_HISTORY;
            ADDR_HIST_CLR: sel = SEL_HIST_CLR;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_autoclear_bit.sv
// One autoclear channel: start pulse, in-progress status and sticky done history.
// Latency: effects visible the cycle after the edge; no backpressure (always accepts).
module bus_autoclear_bit (
    input  logic bus_clk,
    input  logic bus_rst,
    input  logic start_wr,
    input  logic stop_wr,
    input  logic hist_clr_wr,
    input  logic done,
    output logic start_pulse,
    output logic status,
    output logic history
);

    // A done only counts while the channel is in progress, and a same-edge
    // start re-arms the channel instead of completing it.
    logic done_vld;
    assign done_vld = done & status & ~start_wr;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            start_pulse <= 1'b0;
            status      <= 1'b0;
            history     <= 1'b0;
        end else begin
            start_pulse <= start_wr;

            if (start_wr) begin
                status <= 1'b1;
            end else if (stop_wr || done_vld) begin
                status <= 1'b0;
            end

            if (done_vld) begin
                history <= 1'b1;
            end else if (hist_clr_wr) begin
                history <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_autoclear_regs.sv
// Bus-mapped bank of START/STATUS/STOP/HISTORY/HIST_CLR autoclear registers.
// Latency: 1 cycle for read data and register effects; no backpressure (every CS is accepted).
module bus_autoclear_regs
    import bus_autoclear_regs_pkg::*;
#(
    parameter int AC_BITS_USED = 2
) (
    input  logic                    i_Bus_Clk,
    input  logic                    i_Bus_Rst,
    input  logic                    i_Bus_CS,
    input  logic                    i_Bus_Wr_Rd_n,
    input  logic [ADDR_W-1:0]       i_Bus_Addr8,
    input  logic [BUS_DW-1:0]       i_Bus_Wr_Data,
    output logic [BUS_DW-1:0]       o_Bus_Rd_Data,
    output logic                    o_Bus_Rd_DV,
    output logic [AC_BITS_USED-1:0] o_AC_Start,
    input  logic [AC_BITS_USED-1:0] i_AC_Done
);

    reg_sel_e                  sel;
    logic                      wr_vld;
    logic                      rd_vld;
    logic [AC_BITS_USED-1:0]   chan_dat;
    logic [AC_BITS_USED-1:0]   start_wr;
    logic [AC_BITS_USED-1:0]   stop_wr;
    logic [AC_BITS_USED-1:0]   hist_clr_wr;
    logic [AC_BITS_USED-1:0]   status_vec;
    logic [AC_BITS_USED-1:0]   history_vec;
    logic [BUS_DW-1:0]         status_dat;
    logic [BUS_DW-1:0]         history_dat;
    logic [BUS_DW-1:0]         rd_mux_dat;
    logic                      unused_wr_dat;

    assign sel      = decode_addr(i_Bus_Addr8);
    assign wr_vld   = i_Bus_CS &  i_Bus_Wr_Rd_n;
    assign rd_vld   = i_Bus_CS & ~i_Bus_Wr_Rd_n;
    assign chan_dat = i_Bus_Wr_Data[AC_BITS_USED-1:0];

    // Data bits beyond the implemented channels are simply dropped.
    assign unused_wr_dat = ^i_Bus_Wr_Data;

    assign start_wr    = (wr_vld && sel == SEL_START)    ? chan_dat : '0;
    assign stop_wr     = (wr_vld && sel == SEL_STOP)     ? chan_dat : '0;
    assign hist_clr_wr = (wr_vld && sel == SEL_HIST_CLR) ? chan_dat : '0;

    for (genvar n = 0; n < AC_BITS_USED; n++) begin : g_chan
        bus_autoclear_bit u_bit (
            .bus_clk     (i_Bus_Clk),
            .bus_rst     (i_Bus_Rst),
            .start_wr    (start_wr[n]),
            .stop_wr     (stop_wr[n]),
            .hist_clr_wr (hist_clr_wr[n]),
            .done        (i_AC_Done[n]),
            .start_pulse (o_AC_Start[n]),
            .status      (status_vec[n]),
            .history     (history_vec[n])
        );
    end

    always_comb begin
        status_dat                      = '0;
        history_dat                     = '0;
        status_dat[AC_BITS_USED-1:0]    = status_vec;
        history_dat[AC_BITS_USED-1:0]   = history_vec;
    end

    always_comb begin
        rd_mux_dat = '0;
        case (sel)
            SEL_STATUS:  rd_mux_dat = status_dat;
            SEL_HISTORY: rd_mux_dat = history_dat;
            default:     rd_mux_dat = '0;
        endcase
    end

    // Read data is forced to zero outside the valid strobe.
    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            o_Bus_Rd_DV   <= 1'b0;
            o_Bus_Rd_Data <= '0;
        end else begin
            o_Bus_Rd_DV   <= rd_vld;
            o_Bus_Rd_Data <= rd_vld ? rd_mux_dat : '0;
        end
    end

endmodule

// File: tb/tb_bus_autoclear_regs.sv
// Directed bench for bus_autoclear_regs with two channels; expected values are hand-computed.
module tb_bus_autoclear_regs;

    logic        i_Bus_Clk = 1'b0;
    logic        i_Bus_Rst = 1'b1;
    logic        i_Bus_CS = 1'b0;
    logic        i_Bus_Wr_Rd_n = 1'b0;
    logic [3:0]  i_Bus_Addr8 = 4'h0;
    logic [15:0] i_Bus_Wr_Data = 16'h0;
    logic [15:0] o_Bus_Rd_Data;
    logic        o_Bus_Rd_DV;
    logic [1:0]  o_AC_Start;
    logic [1:0]  i_AC_Done = 2'b00;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    bus_autoclear_regs #(.AC_BITS_USED(2)) dut (
        .i_Bus_Clk     (i_Bus_Clk),
        .i_Bus_Rst     (i_Bus_Rst),
        .i_Bus_CS      (i_Bus_CS),
        .i_Bus_Wr_Rd_n (i_Bus_Wr_Rd_n),
        .i_Bus_Addr8   (i_Bus_Addr8),
        .i_Bus_Wr_Data (i_Bus_Wr_Data),
        .o_Bus_Rd_Data (o_Bus_Rd_Data),
        .o_Bus_Rd_DV   (o_Bus_Rd_DV),
        .o_AC_Start    (o_AC_Start),
        .i_AC_Done     (i_AC_Done)
    );

    always #5 i_Bus_Clk = ~i_Bus_Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write on one edge; returns at the falling edge of the following cycle.
    task automatic bus_write(input logic [3:0] addr, input logic [15:0] dat, input logic [1:0] done_v);
        @(negedge i_Bus_Clk);
        i_Bus_CS = 1'b1; i_Bus_Wr_Rd_n = 1'b1; i_Bus_Addr8 = addr; i_Bus_Wr_Data = dat;
        i_AC_Done = done_v;
        @(negedge i_Bus_Clk);
        i_Bus_CS = 1'b0; i_Bus_Wr_Rd_n = 1'b0; i_Bus_Wr_Data = 16'h0; i_AC_Done = 2'b00;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        @(negedge i_Bus_Clk);
        i_Bus_CS = 1'b1; i_Bus_Wr_Rd_n = 1'b0; i_Bus_Addr8 = addr;
        @(negedge i_Bus_Clk);
        i_Bus_CS = 1'b0;
        check({tag, "_dv"}, {15'h0, o_Bus_Rd_DV}, 16'h1);
        check(tag, o_Bus_Rd_Data, exp);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge i_Bus_Clk);
        check("rst_start", {14'h0, o_AC_Start}, 16'h0);
        check("rst_dv", {15'h0, o_Bus_Rd_DV}, 16'h0);
        check("rst_rdata", o_Bus_Rd_Data, 16'h0);
        i_Bus_Rst = 1'b0;
        read_chk("rst_status", 4'h2, 16'h0000);
        read_chk("rst_history", 4'h6, 16'h0000);

        // Start channel 0, then done held two cycles
        bus_write(4'h0, 16'h0001, 2'b00);
        check("start0_pulse", {14'h0, o_AC_Start}, 16'h0001);
        @(negedge i_Bus_Clk);
        check("start0_pulse_end", {14'h0, o_AC_Start}, 16'h0000);
        read_chk("start0_status", 4'h2, 16'h0001);
        @(negedge i_Bus_Clk); i_AC_Done = 2'b01;
        @(negedge i_Bus_Clk);
        @(negedge i_Bus_Clk); i_AC_Done = 2'b00;
        read_chk("done0_history", 4'h6, 16'h0001);
        read_chk("done0_status", 4'h2, 16'h0000);

        // History clear, then an idle done must not set history
        bus_write(4'h8, 16'h0001, 2'b00);
        read_chk("hclr_history", 4'h6, 16'h0000);
        bus_write(4'hA, 16'h0000, 2'b01);
        read_chk("idle_done_history", 4'h6, 16'h0000);

        // Stop channel 1
        bus_write(4'h0, 16'h0002, 2'b00);
        check("start1_pulse", {14'h0, o_AC_Start}, 16'h0002);
        read_chk("start1_status", 4'h2, 16'h0002);
        bus_write(4'h4, 16'h0002, 2'b00);
        check("stop1_no_pulse", {14'h0, o_AC_Start}, 16'h0000);
        read_chk("stop1_status", 4'h2, 16'h0000);
        read_chk("stop1_history", 4'h6, 16'h0000);

        // START and done on the same edge: re-pulse, stay in progress, no history
        bus_write(4'h0, 16'h0001, 2'b00);
        bus_write(4'h0, 16'h0001, 2'b01);
        check("coll_start_pulse", {14'h0, o_AC_Start}, 16'h0001);
        read_chk("coll_start_status", 4'h2, 16'h0001);
        read_chk("coll_start_history", 4'h6, 16'h0000);

        // HIST_CLR and a valid done on the same edge: done wins
        bus_write(4'h8, 16'h0001, 2'b01);
        read_chk("coll_hclr_history", 4'h6, 16'h0001);
        read_chk("coll_hclr_status", 4'h2, 16'h0000);

        // Reset mid-operation: ch0 in progress, HISTORY = 0x2, START written during reset
        bus_write(4'h8, 16'h0001, 2'b00);
        bus_write(4'h0, 16'h0002, 2'b00);
        bus_write(4'hA, 16'h0000, 2'b10);
        bus_write(4'h0, 16'h0001, 2'b00);
        read_chk("pre_rst_status", 4'h2, 16'h0001);
        read_chk("pre_rst_history", 4'h6, 16'h0002);
        @(negedge i_Bus_Clk);
        i_Bus_Rst = 1'b1; i_Bus_CS = 1'b1; i_Bus_Wr_Rd_n = 1'b1;
        i_Bus_Addr8 = 4'h0; i_Bus_Wr_Data = 16'h0003; i_AC_Done = 2'b01;
        @(negedge i_Bus_Clk);
        i_Bus_Rst = 1'b0; i_Bus_CS = 1'b0; i_Bus_Wr_Rd_n = 1'b0;
        i_Bus_Wr_Data = 16'h0; i_AC_Done = 2'b00;
        check("midrst_no_pulse", {14'h0, o_AC_Start}, 16'h0000);
        read_chk("midrst_status", 4'h2, 16'h0000);
        read_chk("midrst_history", 4'h6, 16'h0000);

        // Write-only and undecoded addresses read 0; upper data bits ignored
        bus_write(4'h0, 16'hFFFF, 2'b00);
        check("wide_start_pulse", {14'h0, o_AC_Start}, 16'h0003);
        read_chk("rd_start_addr", 4'h0, 16'h0000);
        read_chk("rd_stop_addr", 4'h4, 16'h0000);
        read_chk("rd_hclr_addr", 4'h8, 16'h0000);
        read_chk("rd_undecoded", 4'hE, 16'h0000);
        bus_write(4'hA, 16'hFFFF, 2'b00);
        check("undecoded_wr_no_pulse", {14'h0, o_AC_Start}, 16'h0000);
        read_chk("wide_status", 4'h2, 16'h0003);

        // Back-to-back reads after done on ch0 only; DV strobe lasts one cycle
        bus_write(4'hA, 16'h0000, 2'b01);
        @(negedge i_Bus_Clk);
        i_Bus_CS = 1'b1; i_Bus_Wr_Rd_n = 1'b0; i_Bus_Addr8 = 4'h2;
        @(negedge i_Bus_Clk);
        i_Bus_Addr8 = 4'h6;
        check("b2b_status_dv", {15'h0, o_Bus_Rd_DV}, 16'h1);
        check("b2b_status", o_Bus_Rd_Data, 16'h0002);
        @(negedge i_Bus_Clk);
        i_Bus_CS = 1'b0;
        check("b2b_history_dv", {15'h0, o_Bus_Rd_DV}, 16'h1);
        check("b2b_history", o_Bus_Rd_Data, 16'h0001);
        @(negedge i_Bus_Clk);
        check("dv_drop", {15'h0, o_Bus_Rd_DV}, 16'h0);
        check("rdata_drop", o_Bus_Rd_Data, 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bus_autoclear_regs.md
Name: bus_autoclear_regs

Overview:
Bus-mapped bank of auto-clearing control/status registers on the 16-bit register bus.
- Software writes Start bits; each write launches a one-cycle start pulse to an external engine and marks that channel in-progress.
- The engine returns a done strobe, which clears in-progress and sets a sticky history bit.
- Software can abort a channel via a Stop register and clear history bits via a History-Clear register.

Parameters:
AC_BITS_USED, 2, number of autoclear channels (1..16); channel n maps to data bit n of every register.

Ports:
i_Bus_Clk  in  1  bus clock; all logic is on the rising edge.
i_Bus_Rst  in  1  synchronous reset, active-high.
i_Bus_CS  in  1  chip select; one-cycle strobe per transaction.
i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read; qualified by i_Bus_CS.
i_Bus_Addr8  in  4  byte address within the bank (even addresses only).
i_Bus_Wr_Data  in  16  write data.
o_Bus_Rd_Data  out  16  read data; valid when o_Bus_Rd_DV = 1.
o_Bus_Rd_DV  out  1  one-cycle read-data-valid strobe.
o_AC_Start  out  AC_BITS_USED  per-channel one-cycle start pulse.
i_AC_Done  in  AC_BITS_USED  per-channel done level/strobe from the engine (synchronous to i_Bus_Clk).

Behaviour:
- Register map (byte address, access):
  - 0x0 START (W, write-1-to-start)
  - 0x2 STATUS (R, in-progress bits)
  - 0x4 STOP (W, write-1-to-stop)
  - 0x6 HISTORY (R, sticky done bits)
  - 0x8 HIST_CLR (W, write-1-to-clear)
- Write-only addresses read 0. Undecoded addresses read 0 and ignore writes. Bits at or above AC_BITS_USED read 0.
- Reset, sampled at a clock edge while i_Bus_Rst = 1: STATUS = 0, HISTORY = 0, o_AC_Start = 0, o_Bus_Rd_DV = 0, o_Bus_Rd_Data = 0. Reset overrides any bus access or done in the same cycle.
- Write (CS = 1, Wr_Rd_n = 1) is captured at the edge; the register effect is visible from the next cycle.
- START write with data bit n = 1, evaluated at edge k:
  - o_AC_Start[n] = 1 for exactly the cycle after edge k.
  - STATUS[n] = 1 from the same cycle.
  - Zero bits have no effect.
  - Writing START to a channel already in progress re-pulses o_AC_Start[n]; STATUS stays 1.
- Done, per channel n, evaluated each edge: if i_AC_Done[n] = 1 and STATUS[n] = 1, then STATUS[n] <= 0 and HISTORY[n] <= 1.
  - Done while STATUS[n] = 0 is ignored, so a multi-cycle done level sets history only once.
- STOP write bit n = 1: STATUS[n] <= 0; HISTORY is unchanged; no pulse is generated.
- HIST_CLR write bit n = 1: HISTORY[n] <= 0.
- Same-edge priority per channel:
  - START write beats done and beats STOP's effect (STOP and START cannot share a cycle); STATUS stays 1.
  - Done beats HIST_CLR: HISTORY is set.
- Read (CS = 1, Wr_Rd_n = 0) at edge k: o_Bus_Rd_Data carries the register value sampled at edge k and o_Bus_Rd_DV = 1 for exactly the cycle after edge k.
- o_Bus_Rd_Data returns to 0 when o_Bus_Rd_DV = 0.
- Back-to-back transactions on consecutive cycles are supported.

Decomposition:
- Shared package holds:
  - address constants ADDR_START = 4'h0, ADDR_STATUS = 4'h2, ADDR_STOP = 4'h4, ADDR_HISTORY = 4'h6, ADDR_HIST_CLR = 4'h8
  - bus data width constant 16
- Bus signals (CS, Wr_Rd_n, Addr8, Wr_Data, Rd_Data, Rd_DV, clock) are bundled by the existing Bus_Interface for benches. The DUT itself uses the plain ports above.
- One natural sub-module: bus_autoclear_bit, holding per-channel STATUS/HISTORY/start-pulse logic, instantiated AC_BITS_USED times by generate.

Test Plan:
- Start, status and done path:
  - Write 0x0 = 0x0001 -> o_AC_Start[0] pulses one cycle; read 0x2 -> bit0 = 1.
  - Then i_AC_Done[0] = 1 for 2 cycles -> read 0x6 bit0 = 1, read 0x2 bit0 = 0.
- History clear: write 0x8 = 0x0001 -> read 0x6 bit0 = 0; a done while idle leaves it 0.
- Stop: write 0x0 = 0x0002 -> read 0x2 bit1 = 1; write 0x4 = 0x0002 -> read 0x2 bit1 = 0, read 0x6 bit1 = 0, no further o_AC_Start pulse.
- Collisions:
  - START write and i_AC_Done[0] on the same edge -> STATUS bit0 = 1, HISTORY unchanged.
  - HIST_CLR write and a valid done on the same edge -> HISTORY bit0 = 1.
- Reset mid-operation: channel 0 in progress and HISTORY = 0x2, assert i_Bus_Rst one cycle -> STATUS = 0, HISTORY = 0, no start pulse.
- Read protocol:
  - o_Bus_Rd_DV is exactly 1 cycle after CS.
  - Reads of 0x0, 0x4, 0x8, 0xE return 0.
  - Bits 15:AC_BITS_USED always read 0.
